// File: rtl/lightcontrol_axi_burst_slave.sv
// AXI4 burst slave for the LightControl VIP: 32-bit register bank with FIXED/INCR/WRAP
// bursts, byte strobes and read back-pressure; light_out mirrors the low bits of word 0.
module lightcontrol_axi_burst_slave #(
   parameter int unsigned ID_W    = 1,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LIGHT_W = 8
) (
   input  logic               s00_axi_aclk,
   input  logic               s00_axi_aresetn,
   input  logic [ID_W-1:0]    awid,
   input  logic [ADDR_W-1:0]  awaddr,
   input  logic [7:0]         awlen,
   input  logic [2:0]         awsize,
   input  logic [1:0]         awburst,
   input  logic               awvalid,
   output logic               awready,
   input  logic [31:0]        wdata,
   input  logic [3:0]         wstrb,
   input  logic               wlast,
   input  logic               wvalid,
   output logic               wready,
   output logic [ID_W-1:0]    bid,
   output logic [1:0]         bresp,
   output logic               bvalid,
   input  logic               bready,
   input  logic [ID_W-1:0]    arid,
   input  logic [ADDR_W-1:0]  araddr,
   input  logic [7:0]         arlen,
   input  logic [2:0]         arsize,
   input  logic [1:0]         arburst,
   input  logic               arvalid,
   output logic               arready,
   output logic [ID_W-1:0]    rid,
   output logic [31:0]        rdata,
   output logic [1:0]         rresp,
   output logic               rlast,
   output logic               rvalid,
   input  logic               rready,
   output logic [LIGHT_W-1:0] light_out
);

   localparam int unsigned AW    = ADDR_W - 2;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   w_state_t      w_state;
   r_state_t      r_state;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] w_addr, w_nxt, r_addr, r_nxt;
   logic [7:0]    w_len, r_len, r_cnt;
   logic [1:0]    w_burst, r_burst;
   logic          w_err, r_err;
   logic [8:0]    w_cnt;
   logic          unused_ok;

   // WRAP keeps the upper index bits and lets the low bits (sized by len) roll over.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                               input logic [1:0]    burst,
                                               input logic [7:0]    len);
      logic [AW-1:0] mask;
      mask = AW'(len);
      case (burst)
         2'b01:   next_addr = a + AW'(1);
         2'b10:   next_addr = (a & ~mask) | ((a + AW'(1)) & mask);
         default: next_addr = a;
      endcase
   endfunction

   function automatic logic burst_err(input logic [2:0] size,
                                      input logic [1:0] burst,
                                      input logic [7:0] len);
      burst_err = (size != 3'b010) || (burst == 2'b11) ||
                  ((burst == 2'b10) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
   endfunction

   always_comb begin
      w_nxt = next_addr(w_addr, w_burst, w_len);
      r_nxt = next_addr(r_addr, r_burst, r_len);
   end

   assign unused_ok = ^{awaddr[1:0], araddr[1:0]};

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         w_state <= W_IDLE;
         awready <= 1'b1;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= '0;
         bid     <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_burst <= '0;
         w_err   <= 1'b0;
         w_cnt   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (w_state)
            W_IDLE: if (awvalid) begin
               w_addr  <= awaddr[ADDR_W-1:2];
               w_len   <= awlen;
               w_burst <= awburst;
               w_err   <= burst_err(awsize, awburst, awlen);
               w_cnt   <= '0;
               bid     <= awid;
               awready <= 1'b0;
               wready  <= 1'b1;
               w_state <= W_DATA;
            end
            W_DATA: if (wvalid) begin
               // Beats past awlen+1 are swallowed; the counter parks at len+1.
               if (!w_err && w_cnt <= {1'b0, w_len})
                  for (int unsigned b = 0; b < 4; b++)
                     if (wstrb[b]) mem[w_addr][8*b +: 8] <= wdata[8*b +: 8];
               if (w_cnt <= {1'b0, w_len}) w_cnt <= w_cnt + 9'd1;
               w_addr <= w_nxt;
               if (wlast) begin
                  wready  <= 1'b0;
                  bvalid  <= 1'b1;
                  bresp   <= (w_err || w_cnt != {1'b0, w_len}) ? 2'b10 : 2'b00;
                  w_state <= W_RESP;
               end
            end
            W_RESP: if (bready) begin
               bvalid  <= 1'b0;
               awready <= 1'b1;
               w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_state <= R_IDLE;
         arready <= 1'b1;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rresp   <= '0;
         rdata   <= '0;
         rid     <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_burst <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (arvalid) begin
               r_addr  <= araddr[ADDR_W-1:2];
               r_len   <= arlen;
               r_burst <= arburst;
               r_err   <= burst_err(arsize, arburst, arlen);
               r_cnt   <= '0;
               rid     <= arid;
               rdata   <= burst_err(arsize, arburst, arlen) ? '0 : mem[araddr[ADDR_W-1:2]];
               rresp   <= burst_err(arsize, arburst, arlen) ? 2'b10 : 2'b00;
               rlast   <= (arlen == 8'd0);
               rvalid  <= 1'b1;
               arready <= 1'b0;
               r_state <= R_DATA;
            end
            R_DATA: if (rready) begin
               if (rlast) begin
                  rvalid  <= 1'b0;
                  rlast   <= 1'b0;
                  arready <= 1'b1;
                  r_state <= R_IDLE;
               end else begin
                  r_addr <= r_nxt;
                  r_cnt  <= r_cnt + 8'd1;
                  rdata  <= r_err ? '0 : mem[r_nxt];
                  rlast  <= (r_cnt + 8'd1 == r_len);
               end
            end
         endcase
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) light_out <= '0;
      else                  light_out <= mem[0][LIGHT_W-1:0];
   end

endmodule

// File: tb/tb_lightcontrol_axi_burst_slave.sv
// Bench for lightcontrol_axi_burst_slave: single-beat vector table plus multi-beat burst,
// back-pressure, error and mid-burst reset sequences; read beats checked from a queue.
module tb_lightcontrol_axi_burst_slave;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [0:0]  awid, bid, arid, rid;
   logic [7:0]  awaddr, awlen, araddr, arlen, light_out;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   lightcontrol_axi_burst_slave #(.ID_W(1), .ADDR_W(8), .LIGHT_W(8)) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .light_out(light_out)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   typedef struct {
      logic [7:0]  addr;
      logic [2:0]  wsize;
      logic [1:0]  wburst;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [2:0]  rsize;
      logic [1:0]  rburst;
      logic [31:0] rdata;
      logic [1:0]  rresp;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   rbeat_t      rq[$];
   logic [1:0]  bq[$];
   logic [31:0] wbuf [16];
   logic [3:0]  sbuf [16];
   vec_t        vt [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no handshake expected one within the cycle budget", name);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
      rq.push_back('{d, r, l});
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int nbeats, input logic id,
                           input logic [1:0] exp_resp);
      logic       seen;
      logic [1:0] eb;
      int         guard;
      bq.push_back(exp_resp);
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      guard = 0;
      do begin seen = awready; tick(); guard++; end while (!seen && guard < 50);
      awvalid = 1'b0;
      if (!seen) begin expire("aw_handshake"); bq.delete(); return; end
      chk("wready_after_aw", 32'(wready), 32'd1);
      chk("awready_busy", 32'(awready), 32'd0);
      for (int i = 0; i < nbeats; i++) begin
         wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1);
         guard = 0;
         do begin seen = wready; tick(); guard++; end while (!seen && guard < 50);
         if (!seen) begin wvalid = 1'b0; expire("w_handshake"); bq.delete(); return; end
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("wready_after_wlast", 32'(wready), 32'd0);
      chk("bvalid_after_wlast", 32'(bvalid), 32'd1);
      bready = 1'b1;
      guard = 0;
      do begin
         seen = bvalid;
         if (seen) begin
            eb = bq.pop_front();
            chk($sformatf("bresp@%h", addr), 32'(bresp), 32'(eb));
            chk("bid", 32'(bid), 32'(id));
         end
         tick(); guard++;
      end while (!seen && guard < 50);
      bready = 1'b0;
      if (!seen) begin expire("b_handshake"); bq.delete(); end
      else chk("awready_after_b", 32'(awready), 32'd1);
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input logic toggle);
      logic seen, hs;
      int   guard, beat;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      guard = 0;
      do begin seen = arready; tick(); guard++; end while (!seen && guard < 50);
      arvalid = 1'b0;
      if (!seen) begin expire("ar_handshake"); rq.delete(); return; end
      chk("rvalid_after_ar", 32'(rvalid), 32'd1);
      guard = 0; beat = 0;
      while (rq.size() > 0 && guard < 600) begin
         rready = toggle ? (guard % 2 == 0) : 1'b1;
         if (!rvalid) begin
            checks++; errors++;
            $display("FAIL rvalid_beat%0d@%h: got 0 expected 1", beat, addr);
            break;
         end
         chk($sformatf("rdata_beat%0d@%h", beat, addr), rdata, rq[0].data);
         chk($sformatf("rresp_beat%0d@%h", beat, addr), 32'(rresp), 32'(rq[0].resp));
         chk($sformatf("rlast_beat%0d@%h", beat, addr), 32'(rlast), 32'(rq[0].last));
         chk("rid", 32'(rid), 32'(id));
         chk("arready_busy", 32'(arready), 32'd0);
         hs = rvalid && rready;
         tick();
         if (hs) begin void'(rq.pop_front()); beat++; end
         guard++;
      end
      rready = 1'b0;
      if (rq.size() > 0) begin expire("r_beats"); rq.delete(); end
      chk("rvalid_after_last", 32'(rvalid), 32'd0);
      chk("arready_after_last", 32'(arready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected one before the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // addr, wsize, wburst, data, strb, bresp, rsize, rburst, rdata, rresp
      vt[0]  = '{8'h60, 3'd2, 2'b01, 32'h12345678, 4'hF, 2'b00, 3'd2, 2'b01, 32'h12345678, 2'b00};
      vt[1]  = '{8'h64, 3'd2, 2'b01, 32'hCAFEBABE, 4'h3, 2'b00, 3'd2, 2'b01, 32'h0000BABE, 2'b00};
      vt[2]  = '{8'h68, 3'd2, 2'b01, 32'hCAFEBABE, 4'hC, 2'b00, 3'd2, 2'b01, 32'hCAFE0000, 2'b00};
      vt[3]  = '{8'h6C, 3'd1, 2'b01, 32'hDEADBEEF, 4'hF, 2'b10, 3'd2, 2'b01, 32'h00000000, 2'b00};
      vt[4]  = '{8'h70, 3'd2, 2'b11, 32'hDEADBEEF, 4'hF, 2'b10, 3'd2, 2'b01, 32'h00000000, 2'b00};
      vt[5]  = '{8'h74, 3'd2, 2'b10, 32'hDEADBEEF, 4'hF, 2'b10, 3'd2, 2'b01, 32'h00000000, 2'b00};
      vt[6]  = '{8'h78, 3'd2, 2'b00, 32'h000000FF, 4'h0, 2'b00, 3'd2, 2'b01, 32'h00000000, 2'b00};
      vt[7]  = '{8'h7C, 3'd2, 2'b00, 32'h5A000000, 4'h8, 2'b00, 3'd2, 2'b00, 32'h5A000000, 2'b00};
      vt[8]  = '{8'h5C, 3'd2, 2'b01, 32'h00000077, 4'hF, 2'b00, 3'd1, 2'b01, 32'h00000000, 2'b10};
      vt[9]  = '{8'h58, 3'd2, 2'b01, 32'h00000099, 4'hF, 2'b00, 3'd2, 2'b11, 32'h00000000, 2'b10};
      vt[10] = '{8'h54, 3'd2, 2'b01, 32'h00000042, 4'hF, 2'b00, 3'd2, 2'b10, 32'h00000000, 2'b10};

      aresetn = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      tick(); tick(); tick();
      aresetn = 1'b1;
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rlast", 32'(rlast), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_light", 32'(light_out), 32'd0);

      // INCR write 1..8 then plain and back-pressured read-back
      for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
      do_write(8'h00, 8'd7, 3'd2, 2'b01, 8, 1'b0, 2'b00);
      for (int i = 0; i < 8; i++) push_r(32'(i + 1), 2'b00, i == 7);
      do_read(8'h00, 8'd7, 3'd2, 2'b01, 1'b1, 1'b0);
      chk("light_after_incr", 32'(light_out), 32'h01);
      for (int i = 0; i < 8; i++) push_r(32'(i + 1), 2'b00, i == 7);
      do_read(8'h00, 8'd7, 3'd2, 2'b01, 1'b0, 1'b1);

      // byte strobes
      wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
      do_write(8'h04, 8'd0, 3'd2, 2'b01, 1, 1'b1, 2'b00);
      wbuf[0] = 32'h11223344; sbuf[0] = 4'h5;
      do_write(8'h04, 8'd0, 3'd2, 2'b01, 1, 1'b0, 2'b00);
      push_r(32'hAA22CC44, 2'b00, 1'b1);
      do_read(8'h04, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0);

      // WRAP len 3 from 0x18, then FIXED len 3 to 0x20
      wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
      for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
      do_write(8'h18, 8'd3, 3'd2, 2'b10, 4, 1'b1, 2'b00);
      push_r(32'hC, 2'b00, 1'b0); push_r(32'hD, 2'b00, 1'b0);
      push_r(32'hA, 2'b00, 1'b0); push_r(32'hB, 2'b00, 1'b1);
      do_read(8'h10, 8'd3, 3'd2, 2'b01, 1'b0, 1'b0);
      push_r(32'hA, 2'b00, 1'b0); push_r(32'hA, 2'b00, 1'b0); push_r(32'hA, 2'b00, 1'b1);
      do_read(8'h18, 8'd2, 3'd2, 2'b00, 1'b1, 1'b0);
      wbuf[0] = 32'h1111; wbuf[1] = 32'h2222; wbuf[2] = 32'h3333; wbuf[3] = 32'h4444;
      do_write(8'h20, 8'd3, 3'd2, 2'b00, 4, 1'b0, 2'b00);
      push_r(32'h4444, 2'b00, 1'b0); push_r(32'h0, 2'b00, 1'b1);
      do_read(8'h20, 8'd1, 3'd2, 2'b01, 1'b0, 1'b0);

      // single-beat vector table
      for (int i = 0; i < 11; i++) begin
         wbuf[0] = vt[i].data; sbuf[0] = vt[i].strb;
         do_write(vt[i].addr, 8'd0, vt[i].wsize, vt[i].wburst, 1, i[0], vt[i].bresp);
         push_r(vt[i].rdata, vt[i].rresp, 1'b1);
         do_read(vt[i].addr, 8'd0, vt[i].rsize, vt[i].rburst, ~i[0], 1'b0);
      end

      // bad awsize burst, early wlast, late wlast
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hDEAD0000 + 32'(i); sbuf[i] = 4'hF; end
      do_write(8'h30, 8'd3, 3'd1, 2'b01, 4, 1'b0, 2'b10);
      for (int i = 0; i < 4; i++) push_r(32'h0, 2'b00, i == 3);
      do_read(8'h30, 8'd3, 3'd2, 2'b01, 1'b0, 1'b0);
      wbuf[0] = 32'h40; wbuf[1] = 32'h41; wbuf[2] = 32'h42;
      do_write(8'h40, 8'd3, 3'd2, 2'b01, 3, 1'b0, 2'b10);
      push_r(32'h40, 2'b00, 1'b0); push_r(32'h41, 2'b00, 1'b0);
      push_r(32'h42, 2'b00, 1'b0); push_r(32'h0, 2'b00, 1'b1);
      do_read(8'h40, 8'd3, 3'd2, 2'b01, 1'b0, 1'b0);
      wbuf[0] = 32'h50; wbuf[1] = 32'h51; wbuf[2] = 32'h52;
      do_write(8'h50, 8'd1, 3'd2, 2'b01, 3, 1'b1, 2'b10);
      push_r(32'h50, 2'b00, 1'b0); push_r(32'h51, 2'b00, 1'b0); push_r(32'h99, 2'b00, 1'b1);
      do_read(8'h50, 8'd2, 3'd2, 2'b01, 1'b0, 1'b0);

      // light_out follows word 0
      wbuf[0] = 32'h000000A5; sbuf[0] = 4'h1;
      do_write(8'h00, 8'd0, 3'd2, 2'b01, 1, 1'b0, 2'b00);
      tick();
      chk("light_after_word0", 32'(light_out), 32'hA5);

      // reset while beat 3 of a read is presented
      arid = 1'b1; araddr = 8'h00; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
      chk("arready_before_rst_read", 32'(arready), 32'd1);
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0; rready = 1'b1;
      tick(); tick(); tick();
      chk("rvalid_beat3_pre_rst", 32'(rvalid), 32'd1);
      chk("rdata_beat3_pre_rst", rdata, 32'd4);
      aresetn = 1'b0; rready = 1'b0;
      tick();
      aresetn = 1'b1;
      chk("midrst_rvalid", 32'(rvalid), 32'd0);
      chk("midrst_arready", 32'(arready), 32'd1);
      chk("midrst_rlast", 32'(rlast), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      chk("midrst_light", 32'(light_out), 32'd0);
      chk("midrst_bvalid", 32'(bvalid), 32'd0);
      for (int i = 0; i < 64; i++) push_r(32'h0, 2'b00, i == 63);
      do_read(8'h00, 8'd63, 3'd2, 2'b01, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lightcontrol_axi_burst_slave.md
# lightcontrol_axi_burst_slave

AXI4 (full) memory-mapped slave that answers the burst write/read transactions issued by the LightControl AXI master VIP on the S00_AXI interface. It holds a small register bank, accepts FIXED/INCR/WRAP bursts with byte strobes, returns read bursts with back-pressure support, and drives the light-control outputs from word 0 of the bank.

## Interface
- ID_W, 1: AXI ID width.
- ADDR_W, 8: byte address width; bank depth = 2^(ADDR_W-2) 32-bit words.
- LIGHT_W, 8: width of light_out, taken from word 0 bits [LIGHT_W-1:0].
- s00_axi_aclk  in  1  sole clock, rising edge.
- s00_axi_aresetn  in  1  synchronous, active-low reset.
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address; awvalid in 1, awready out 1.
- wdata/wstrb/wlast  in  32/4/1  write data; wvalid in 1, wready out 1.
- bid/bresp  out  ID_W/2  write response; bvalid out 1, bready in 1.
- arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address; arvalid in 1, arready out 1.
- rid/rdata/rresp/rlast  out  ID_W/32/2/1  read data; rvalid out 1, rready in 1.
- light_out  out  LIGHT_W  word 0 low bits, registered.
- AxLOCK/CACHE/PROT/QOS/REGION/USER are not ported; the wrapper ties them off.

## Operation
- Write and read channels are independent FSMs; one outstanding burst per channel; both may run concurrently.
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch id/addr/len/size/burst -> W_DATA (wready=1) -> on beat with wlast -> W_RESP (bvalid=1) -> on bready -> W_IDLE.
- Each W_DATA beat writes the bytes enabled by wstrb to the current word, then advances the address.
- Beat counter compares against awlen: beats beyond awlen+1 are accepted but not written; wlast before or after beat awlen+1 -> BRESP=SLVERR (2'b10), else OKAY.
- Read FSM: R_IDLE (arready=1) -> on AR handshake latch -> R_DATA (rvalid=1) -> advance only on rready; rlast asserted on beat arlen; last handshake -> R_IDLE.
- Address update, per burst type: FIXED keeps the address; INCR adds 4 and wraps modulo bank size; WRAP adds 4 within a (len+1)*4-byte block aligned to that size.
- Errors: AxSIZE != 3'b010, AxBURST == 2'b11, or WRAP with len not in {1,3,7,15} -> burst still fully handshaken; writes suppressed, BRESP=SLVERR; reads return rdata=0, RRESP=SLVERR on every beat.
- bid/rid echo the latched awid/arid.
- Same-cycle write and read of one word: read returns pre-write data; the next beat sees new data.
- light_out updates the cycle after a write to word 0 commits.

## Timing
- Reset (aresetn low at a rising edge): awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0, rdata=0, all bank words=0, light_out=0, FSMs to IDLE. Reset mid-burst aborts immediately; no response is issued for the aborted burst.
- AW handshake at cycle N -> wready=1 from N+1; one beat per cycle while wvalid stays high.
- wlast handshake at M -> wready=0 and bvalid=1 at M+1; bvalid holds until bready; awready=1 the cycle after the B handshake.
- AR handshake at N -> rvalid=1 with beat 0 at N+1; with rready held high, beats are back-to-back (len+1 cycles).
- rready low: rdata/rresp/rlast/rid held stable.
- Last R handshake at K -> rvalid=0 and arready=1 at K+1.
- awready/arready are low whenever their FSM is not IDLE.

## Test plan
- INCR burst, addr 0x00, len 7, data 1..8, wstrb 0xF -> BRESP OKAY; INCR read at 0x00, len 7 returns 1..8, rlast only on beat 7, RRESP OKAY; light_out=0x01.
- Write 0xAABBCCDD to 0x04, then 0x11223344 with wstrb 0x5 -> read 0x04 returns 0xAA22CC44.
- WRAP, len 3, addr 0x18, data A,B,C,D -> words 0x18,0x1C,0x10,0x14 hold A,B,C,D; FIXED, len 3 to 0x20 -> 0x20 holds last beat.
- Read burst len 7 with rready toggling 1-0-1-0 -> rdata stable while stalled, 8 beats in order, arready low until the cycle after the final handshake.
- awsize=3'b001 write -> BRESP SLVERR, bank unchanged; wlast on beat 2 of a len-3 burst -> SLVERR, beats 0-2 written.
- aresetn low for one cycle during R_DATA beat 3 -> next cycle rvalid=0, arready=1, all words 0, light_out=0.
